// File: rtl/machine_mode_types_1_12_pkg.sv
// Machine-mode shared types for the privilege block.
// Holds the trap sequencer state encoding, the exception and interrupt
// mcause codes, the mtvec mode constant and the trap vector helper.
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INT_REQ  = 2'd1,
    REDIRECT = 2'd2
  } trap_state_t;

  // Synchronous exception codes
  localparam logic [4:0] EXC_MAL_INSN    = 5'd0;
  localparam logic [4:0] EXC_FAULT_INSN  = 5'd1;
  localparam logic [4:0] EXC_ILLEGAL     = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT  = 5'd3;
  localparam logic [4:0] EXC_MAL_L       = 5'd4;
  localparam logic [4:0] EXC_FAULT_L     = 5'd5;
  localparam logic [4:0] EXC_MAL_S       = 5'd6;
  localparam logic [4:0] EXC_FAULT_S     = 5'd7;
  localparam logic [4:0] EXC_ENV         = 5'd11;

  // Interrupt codes (mcause[31] set separately)
  localparam logic [4:0] INT_SOFT        = 5'd3;
  localparam logic [4:0] INT_TIMER       = 5'd7;
  localparam logic [4:0] INT_EXT         = 5'd11;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // Vectored mode only offsets interrupts; exceptions always go to base.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        is_int,
                                              input logic [4:0]  code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (is_int && (mtvec[1:0] == MTVEC_MODE_VECTORED))
      trap_target = base + {25'd0, code, 2'b00};
    else
      trap_target = base;
  endfunction

endpackage

// File: rtl/prv_trap_priority.sv
// Combinational trap priority encoder.
// Inputs : exception flags, RISC-MGMT exception + index, pending interrupt
//          lines, their enables and the global mstatus.MIE.
// Outputs: valid (any request), is_int (winner is an interrupt), code
//          (mcause code without bit 31), use_badaddr (mtval takes badaddr).
// Any exception outranks any interrupt.
module prv_trap_priority
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int RMGMT_CAUSE_W    = 2,
  parameter int RMGMT_CAUSE_BASE = 24
) (
  input  logic                     fault_insn,
  input  logic                     mal_insn,
  input  logic                     illegal_insn,
  input  logic                     breakpoint,
  input  logic                     env,
  input  logic                     mal_s,
  input  logic                     mal_l,
  input  logic                     fault_s,
  input  logic                     fault_l,
  input  logic                     ex_rmgmt,
  input  logic [RMGMT_CAUSE_W-1:0] ex_rmgmt_cause,
  input  logic                     timer_int,
  input  logic                     soft_int,
  input  logic                     ext_int,
  input  logic                     mie_mtie,
  input  logic                     mie_msie,
  input  logic                     mie_meie,
  input  logic                     mstatus_mie,
  output logic                     valid,
  output logic                     is_int,
  output logic [4:0]               code,
  output logic                     use_badaddr
);

  logic [4:0] rmgmt_code;
  logic       ext_en, soft_en, timer_en;

  assign rmgmt_code = 5'(RMGMT_CAUSE_BASE) + 5'(ex_rmgmt_cause);
  assign ext_en     = mstatus_mie & ext_int   & mie_meie;
  assign soft_en    = mstatus_mie & soft_int  & mie_msie;
  assign timer_en   = mstatus_mie & timer_int & mie_mtie;

  always_comb begin
    valid       = 1'b1;
    is_int      = 1'b0;
    code        = '0;
    use_badaddr = 1'b0;
    if (fault_insn) begin
      code = EXC_FAULT_INSN; use_badaddr = 1'b1;
    end else if (mal_insn) begin
      code = EXC_MAL_INSN;   use_badaddr = 1'b1;
    end else if (illegal_insn) begin
      code = EXC_ILLEGAL;
    end else if (breakpoint) begin
      code = EXC_BREAKPOINT;
    end else if (env) begin
      code = EXC_ENV;
    end else if (mal_s) begin
      code = EXC_MAL_S;      use_badaddr = 1'b1;
    end else if (mal_l) begin
      code = EXC_MAL_L;      use_badaddr = 1'b1;
    end else if (fault_s) begin
      code = EXC_FAULT_S;    use_badaddr = 1'b1;
    end else if (fault_l) begin
      code = EXC_FAULT_L;    use_badaddr = 1'b1;
    end else if (ex_rmgmt) begin
      code = rmgmt_code;
    end else if (ext_en) begin
      is_int = 1'b1; code = INT_EXT;
    end else if (soft_en) begin
      is_int = 1'b1; code = INT_SOFT;
    end else if (timer_en) begin
      is_int = 1'b1; code = INT_TIMER;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Trap sequencer between the hazard unit handshake and the M-mode CSR file.
// Inputs : exception flags, RISC-MGMT exception, ret, pipe_clear, epc,
//          badaddr, pending interrupt lines and enables, mtvec, mepc.
// Outputs: intr (flush request), insert_pc/priv_pc (one-cycle redirect),
//          trap_wen/ret_wen (one-cycle CSR commit strobes) and the
//          mepc/mcause/mtval write data, valid while trap_wen is high.
// Every output is a register or a decode of the state register.
module prv_trap_sequencer
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int RMGMT_CAUSE_W    = 2,
  parameter int RMGMT_CAUSE_BASE = 24
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     fault_insn,
  input  logic                     mal_insn,
  input  logic                     illegal_insn,
  input  logic                     breakpoint,
  input  logic                     env,
  input  logic                     mal_s,
  input  logic                     mal_l,
  input  logic                     fault_s,
  input  logic                     fault_l,
  input  logic                     ex_rmgmt,
  input  logic [RMGMT_CAUSE_W-1:0] ex_rmgmt_cause,
  input  logic                     ret,
  input  logic                     pipe_clear,
  input  logic [31:0]              epc,
  input  logic [31:0]              badaddr,
  input  logic                     timer_int,
  input  logic                     soft_int,
  input  logic                     ext_int,
  input  logic                     mie_mtie,
  input  logic                     mie_msie,
  input  logic                     mie_meie,
  input  logic                     mstatus_mie,
  input  logic [31:0]              mtvec,
  input  logic [31:0]              mepc,
  output logic                     intr,
  output logic                     insert_pc,
  output logic [31:0]              priv_pc,
  output logic                     trap_wen,
  output logic                     ret_wen,
  output logic [31:0]              mepc_wdata,
  output logic [31:0]              mcause_wdata,
  output logic [31:0]              mtval_wdata
);

  trap_state_t state, state_next;

  logic       pri_valid, pri_is_int, pri_use_badaddr;
  logic [4:0] pri_code;
  logic [4:0] int_code;
  logic       is_ret;
  logic       take_exc, take_ret, int_enter, int_commit;
  logic       exc_req, int_req;

  // Exceptions are only actionable together with pipe_clear, so they are
  // gated before the encoder. Without pipe_clear the encoder then reports
  // the winning interrupt, which is what IDLE needs to start a flush.
  prv_trap_priority #(
    .RMGMT_CAUSE_W    (RMGMT_CAUSE_W),
    .RMGMT_CAUSE_BASE (RMGMT_CAUSE_BASE)
  ) u_priority (
    .fault_insn     (fault_insn   & pipe_clear),
    .mal_insn       (mal_insn     & pipe_clear),
    .illegal_insn   (illegal_insn & pipe_clear),
    .breakpoint     (breakpoint   & pipe_clear),
    .env            (env          & pipe_clear),
    .mal_s          (mal_s        & pipe_clear),
    .mal_l          (mal_l        & pipe_clear),
    .fault_s        (fault_s      & pipe_clear),
    .fault_l        (fault_l      & pipe_clear),
    .ex_rmgmt       (ex_rmgmt     & pipe_clear),
    .ex_rmgmt_cause (ex_rmgmt_cause),
    .timer_int      (timer_int),
    .soft_int       (soft_int),
    .ext_int        (ext_int),
    .mie_mtie       (mie_mtie),
    .mie_msie       (mie_msie),
    .mie_meie       (mie_meie),
    .mstatus_mie    (mstatus_mie),
    .valid          (pri_valid),
    .is_int         (pri_is_int),
    .code           (pri_code),
    .use_badaddr    (pri_use_badaddr)
  );

  assign exc_req = pri_valid & ~pri_is_int;
  assign int_req = pri_valid &  pri_is_int;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_exc   = 1'b0;
    take_ret   = 1'b0;
    int_enter  = 1'b0;
    int_commit = 1'b0;
    unique case (state)
      IDLE: begin
        if (exc_req) begin
          take_exc = 1'b1;  state_next = REDIRECT;
        end else if (ret && pipe_clear) begin
          take_ret = 1'b1;  state_next = REDIRECT;
        end else if (int_req) begin
          int_enter = 1'b1; state_next = INT_REQ;
        end
      end
      INT_REQ: begin
        if (exc_req) begin
          take_exc = 1'b1;   state_next = REDIRECT;
        end else if (pipe_clear) begin
          int_commit = 1'b1; state_next = REDIRECT;
        end
      end
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      int_code     <= '0;
      is_ret       <= 1'b0;
      priv_pc      <= '0;
      mepc_wdata   <= '0;
      mcause_wdata <= '0;
      mtval_wdata  <= '0;
    end else begin
      if (int_enter) int_code <= pri_code;
      if (take_exc) begin
        is_ret       <= 1'b0;
        priv_pc      <= trap_target(mtvec, 1'b0, pri_code);
        mepc_wdata   <= epc;
        mcause_wdata <= {1'b0, 26'd0, pri_code};
        mtval_wdata  <= pri_use_badaddr ? badaddr : '0;
      end else if (take_ret) begin
        is_ret       <= 1'b1;
        priv_pc      <= mepc;
      end else if (int_commit) begin
        is_ret       <= 1'b0;
        priv_pc      <= trap_target(mtvec, 1'b1, int_code);
        mepc_wdata   <= epc;
        mcause_wdata <= {1'b1, 26'd0, int_code};
        mtval_wdata  <= '0;
      end
    end
  end

  assign intr      = (state == INT_REQ);
  assign insert_pc = (state == REDIRECT);
  assign trap_wen  = (state == REDIRECT) & ~is_ret;
  assign ret_wen   = (state == REDIRECT) &  is_ret;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
module tb_prv_trap_sequencer;

  logic        CLK, nRST;
  logic        fault_insn, mal_insn, illegal_insn, breakpoint, env;
  logic        mal_s, mal_l, fault_s, fault_l, ex_rmgmt;
  logic [1:0]  ex_rmgmt_cause;
  logic        ret, pipe_clear;
  logic [31:0] epc, badaddr, mtvec, mepc;
  logic        timer_int, soft_int, ext_int;
  logic        mie_mtie, mie_msie, mie_meie, mstatus_mie;
  logic        intr, insert_pc, trap_wen, ret_wen;
  logic [31:0] priv_pc, mepc_wdata, mcause_wdata, mtval_wdata;

  int checks;
  int failures;

  prv_trap_sequencer #(.RMGMT_CAUSE_W(2), .RMGMT_CAUSE_BASE(24)) dut (
    .CLK(CLK), .nRST(nRST),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .breakpoint(breakpoint), .env(env), .mal_s(mal_s), .mal_l(mal_l),
    .fault_s(fault_s), .fault_l(fault_l), .ex_rmgmt(ex_rmgmt),
    .ex_rmgmt_cause(ex_rmgmt_cause), .ret(ret), .pipe_clear(pipe_clear),
    .epc(epc), .badaddr(badaddr), .timer_int(timer_int), .soft_int(soft_int),
    .ext_int(ext_int), .mie_mtie(mie_mtie), .mie_msie(mie_msie),
    .mie_meie(mie_meie), .mstatus_mie(mstatus_mie), .mtvec(mtvec), .mepc(mepc),
    .intr(intr), .insert_pc(insert_pc), .priv_pc(priv_pc), .trap_wen(trap_wen),
    .ret_wen(ret_wen), .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata),
    .mtval_wdata(mtval_wdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  typedef struct { bit hit; int code; bit tv; } trap_t;

  // f bit order: 0 fault_insn,1 mal_insn,2 illegal,3 breakpoint,4 env,
  // 5 mal_s,6 mal_l,7 fault_s,8 fault_l,9 ex_rmgmt (priority order)
  function automatic trap_t ref_exc(input logic [9:0] f, input logic [1:0] rc);
    int codes [10];
    bit tvs   [10];
    trap_t r;
    codes = '{1, 0, 2, 3, 11, 6, 4, 7, 5, 24};
    tvs   = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 0};
    r.hit = 0; r.code = 0; r.tv = 0;
    for (int i = 0; i < 10; i++)
      if (f[i] && !r.hit) begin
        r.hit  = 1;
        r.code = codes[i] + ((i == 9) ? int'(rc) : 0);
        r.tv   = tvs[i];
      end
    return r;
  endfunction

  // lines/en bit order: 2 ext, 1 soft, 0 timer
  function automatic trap_t ref_int(input logic [2:0] lines, input logic [2:0] en,
                                    input logic gie);
    trap_t r;
    logic [2:0] p;
    p = lines & en;
    r.hit = 0; r.code = 0; r.tv = 0;
    if (gie) begin
      if (p[2])      begin r.hit = 1; r.code = 11; end
      else if (p[1]) begin r.hit = 1; r.code = 3;  end
      else if (p[0]) begin r.hit = 1; r.code = 7;  end
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] tv, input bit is_int,
                                             input int code);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
    if (is_int && (tv % 4 == 1)) return base + 32'(code * 4);
    return base;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_exc(input logic [9:0] f);
    {ex_rmgmt, fault_l, fault_s, mal_l, mal_s, env, breakpoint, illegal_insn,
     mal_insn, fault_insn} = f;
  endtask

  task automatic set_int(input logic [2:0] lines, input logic [2:0] en, input logic gie);
    {ext_int, soft_int, timer_int} = lines;
    {mie_meie, mie_msie, mie_mtie} = en;
    mstatus_mie = gie;
  endtask

  task automatic clear_inputs();
    set_exc('0);
    set_int('0, '0, 1'b0);
    ex_rmgmt_cause = '0; ret = 0; pipe_clear = 0;
    epc = '0; badaddr = '0; mtvec = '0; mepc = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nRST = 1'b0;
    clear_inputs();
    tick(); tick();
    checks++;
    if ({intr, insert_pc, trap_wen, ret_wen} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {intr, insert_pc, trap_wen, ret_wen});
    end
    checks++;
    if ({priv_pc, mepc_wdata, mcause_wdata, mtval_wdata} !== 128'd0) begin
      failures++; $display("FAIL reset_data got=%h %h %h %h exp=0", priv_pc, mepc_wdata, mcause_wdata, mtval_wdata);
    end
    nRST = 1'b1;
    tick();
    checks++;
    if ({intr, insert_pc} !== 2'b00) begin
      failures++; $display("FAIL reset_release got=%b exp=00", {intr, insert_pc});
    end
  endtask

  task automatic test_illegal();
    illegal_insn = 1; epc = 32'h100; pipe_clear = 1; mtvec = 32'h200; badaddr = 32'h1234_5678;
    tick();
    clear_inputs();
    checks++;
    if ({insert_pc, trap_wen, ret_wen, intr} !== 4'b1100) begin
      failures++; $display("FAIL illegal_strobes got=%b exp=1100", {insert_pc, trap_wen, ret_wen, intr});
    end
    checks++;
    if (priv_pc !== 32'h200) begin failures++; $display("FAIL illegal_pc got=%h exp=200", priv_pc); end
    checks++;
    if ({mcause_wdata, mepc_wdata, mtval_wdata} !== {32'd2, 32'h100, 32'd0}) begin
      failures++; $display("FAIL illegal_csr got=%h %h %h exp=2 100 0", mcause_wdata, mepc_wdata, mtval_wdata);
    end
    tick();
    checks++;
    if ({insert_pc, trap_wen} !== 2'b00) begin
      failures++; $display("FAIL illegal_oneshot got=%b exp=00", {insert_pc, trap_wen});
    end
  endtask

  task automatic test_mal_s_fault_l();
    mal_s = 1; fault_l = 1; badaddr = 32'hDEAD_BEE0; epc = 32'h180; mtvec = 32'h200; pipe_clear = 1;
    tick();
    clear_inputs();
    checks++;
    if ({mcause_wdata, mtval_wdata, mepc_wdata} !== {32'd6, 32'hDEAD_BEE0, 32'h180}) begin
      failures++; $display("FAIL mal_s_prio got=%h %h %h exp=6 deadbee0 180", mcause_wdata, mtval_wdata, mepc_wdata);
    end
    tick();
  endtask

  task automatic test_timer_vectored();
    set_int(3'b001, 3'b001, 1'b1); mtvec = 32'h201;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({intr, insert_pc} !== 2'b10) begin
        failures++; $display("FAIL timer_hold%0d got=%b exp=10", i, {intr, insert_pc});
      end
    end
    pipe_clear = 1; epc = 32'h300;
    tick();
    clear_inputs();
    checks++;
    if ({intr, insert_pc, trap_wen, priv_pc} !== {3'b011, 32'h21C}) begin
      failures++; $display("FAIL timer_redirect got=%b %h exp=011 21c", {intr, insert_pc, trap_wen}, priv_pc);
    end
    checks++;
    if ({mcause_wdata, mepc_wdata, mtval_wdata} !== {32'h8000_0007, 32'h300, 32'd0}) begin
      failures++; $display("FAIL timer_csr got=%h %h %h exp=80000007 300 0", mcause_wdata, mepc_wdata, mtval_wdata);
    end
    tick();
  endtask

  task automatic test_ext_drop();
    set_int(3'b101, 3'b101, 1'b1); mtvec = 32'h201;
    tick();
    timer_int = 0;
    tick();
    ext_int = 0;
    tick();
    checks++;
    if (intr !== 1'b1) begin failures++; $display("FAIL ext_drop_hold got=%b exp=1", intr); end
    pipe_clear = 1; epc = 32'h440;
    tick();
    clear_inputs();
    checks++;
    if ({mcause_wdata, priv_pc, intr} !== {32'h8000_000B, 32'h22C, 1'b0}) begin
      failures++; $display("FAIL ext_drop_cause got=%h %h %b exp=8000000b 22c 0", mcause_wdata, priv_pc, intr);
    end
    tick();
  endtask

  task automatic test_mret();
    ret = 1; pipe_clear = 1; mepc = 32'h4000; mtvec = 32'h200;
    tick();
    clear_inputs();
    checks++;
    if ({insert_pc, ret_wen, trap_wen, priv_pc} !== {3'b110, 32'h4000}) begin
      failures++; $display("FAIL mret got=%b %h exp=110 4000", {insert_pc, ret_wen, trap_wen}, priv_pc);
    end
    tick();
  endtask

  task automatic test_no_request();
    pipe_clear = 1; set_int(3'b111, 3'b111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({intr, insert_pc} !== 2'b00) begin
        failures++; $display("FAIL no_request%0d got=%b exp=00", i, {intr, insert_pc});
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    illegal_insn = 1; pipe_clear = 1; mtvec = 32'h200;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (insert_pc !== ((i % 2) == 0)) begin
        failures++; $display("FAIL back_to_back%0d got=%b exp=%b", i, insert_pc, (i % 2) == 0);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_abort();
    set_int(3'b010, 3'b010, 1'b1);
    tick();
    checks++;
    if (intr !== 1'b1) begin failures++; $display("FAIL abort_enter got=%b exp=1", intr); end
    clear_inputs(); pipe_clear = 1;
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({intr, insert_pc} !== 2'b00) begin
      failures++; $display("FAIL abort_int_async got=%b exp=00", {intr, insert_pc});
    end
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({insert_pc, trap_wen, ret_wen} !== 3'b000) begin
        failures++; $display("FAIL abort_int_quiet%0d got=%b exp=000", i, {insert_pc, trap_wen, ret_wen});
      end
    end
    // abort during the redirect cycle itself
    breakpoint = 1; pipe_clear = 1; mtvec = 32'h200;
    tick();
    clear_inputs();
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({insert_pc, trap_wen} !== 2'b00) begin
      failures++; $display("FAIL abort_redirect got=%b exp=00", {insert_pc, trap_wen});
    end
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [9:0]  f;
    logic [2:0]  lines, en;
    logic [31:0] tv, r;
    logic        gie, pc, rt;
    trap_t       er, ir, er2;
    int          icode;
    for (int unsigned it = 0; it < 80; it++) begin
      r = $urandom; f = r[9:0];
      r = $urandom; f = f & r[9:0];
      r = $urandom; f = f & r[9:0];
      if ($urandom_range(0, 2) == 0) f = '0;
      r = $urandom; lines = r[2:0]; en = r[5:3]; gie = ($urandom_range(0, 3) != 0);
      ex_rmgmt_cause = r[7:6];
      pc = $urandom_range(0, 1); rt = ($urandom_range(0, 3) == 0);
      tv = $urandom; tv[1:0] = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
      set_exc(f); set_int(lines, en, gie);
      ret = rt; pipe_clear = pc; mtvec = tv;
      epc = $urandom; badaddr = $urandom; mepc = $urandom;
      er = ref_exc(f, ex_rmgmt_cause);
      ir = ref_int(lines, en, gie);
      tick();
      if (er.hit && pc) begin
        checks++;
        if ({insert_pc, trap_wen, ret_wen, intr, priv_pc, mcause_wdata, mepc_wdata, mtval_wdata} !==
            {4'b1100, ref_target(tv, 0, er.code), 32'(er.code), epc, (er.tv ? badaddr : 32'd0)}) begin
          failures++;
          $display("FAIL rand_exc it=%0d got=%b %h %h %h %h exp code=%0d tgt=%h", it,
                   {insert_pc, trap_wen, ret_wen, intr}, priv_pc, mcause_wdata, mepc_wdata, mtval_wdata,
                   er.code, ref_target(tv, 0, er.code));
        end
      end else if (rt && pc) begin
        checks++;
        if ({insert_pc, trap_wen, ret_wen, intr, priv_pc} !== {4'b1010, mepc}) begin
          failures++;
          $display("FAIL rand_ret it=%0d got=%b %h exp=1010 %h", it, {insert_pc, trap_wen, ret_wen, intr}, priv_pc, mepc);
        end
      end else if (ir.hit) begin
        icode = ir.code;
        checks++;
        if ({intr, insert_pc} !== 2'b10) begin
          failures++; $display("FAIL rand_intr it=%0d got=%b exp=10", it, {intr, insert_pc});
        end
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          r = $urandom; set_exc(r[9:0]); set_int(r[12:10], r[15:13], r[16]);
          ret = r[17]; pipe_clear = 0;
          tick();
          checks++;
          if ({intr, insert_pc} !== 2'b10) begin
            failures++; $display("FAIL rand_intr_hold it=%0d got=%b exp=10", it, {intr, insert_pc});
          end
        end
        r = $urandom; f = (r[0]) ? r[10:1] : '0;
        set_exc(f); set_int(r[13:11], r[16:14], r[17]); ret = r[18];
        pipe_clear = 1; epc = $urandom; badaddr = $urandom;
        er2 = ref_exc(f, ex_rmgmt_cause);
        tick();
        if (er2.hit) begin
          checks++;
          if ({insert_pc, trap_wen, intr, priv_pc, mcause_wdata, mepc_wdata, mtval_wdata} !==
              {3'b110, ref_target(tv, 0, er2.code), 32'(er2.code), epc, (er2.tv ? badaddr : 32'd0)}) begin
            failures++;
            $display("FAIL rand_int_preempt it=%0d got=%b %h %h exp code=%0d", it,
                     {insert_pc, trap_wen, intr}, priv_pc, mcause_wdata, er2.code);
          end
        end else begin
          checks++;
          if ({insert_pc, trap_wen, ret_wen, intr, priv_pc, mcause_wdata, mepc_wdata, mtval_wdata} !==
              {4'b1100, ref_target(tv, 1, icode), 32'h8000_0000 | 32'(icode), epc, 32'd0}) begin
            failures++;
            $display("FAIL rand_int_commit it=%0d got=%b %h %h exp code=%0d tgt=%h", it,
                     {insert_pc, trap_wen, ret_wen, intr}, priv_pc, mcause_wdata, icode,
                     ref_target(tv, 1, icode));
          end
        end
      end else begin
        checks++;
        if ({intr, insert_pc, trap_wen, ret_wen} !== 4'b0000) begin
          failures++; $display("FAIL rand_idle it=%0d got=%b exp=0000", it, {intr, insert_pc, trap_wen, ret_wen});
        end
      end
      clear_inputs();
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_illegal();
    test_mal_s_fault_l();
    test_timer_vectored();
    test_ext_drop();
    test_mret();
    test_no_request();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
